pdm_sample_feeder: RTL and testbench

//   Upstream sample scheduler for the PDM channel modulator. Buffers samples written by
//   the bus-side producer in a small FIFO and releases them at a fixed sample rate.
//   At each sample instant it drives out_data and pulses out_stb for one clk, which the
//   PDM channel captures as its new level. Underruns are counted and never stall the

---
 rtl/pdm_sample_feeder_if.sv | 28 ++
 rtl/pdm_sample_feeder.sv | 113 +++++++++++
 tb/tb_pdm_sample_feeder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pdm_sample_feeder_if.sv
// Producer/consumer bundle for the PDM sample feeder.
// The master side is the bus producer and its controls. The slave side is the feeder.
interface pdm_sample_feeder_if #(
  parameter int BITS  = 16,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            out_stb;
  logic [BITS-1:0] out_data;
  logic [LW-1:0]   level;
  logic [15:0]     underrun_cnt;
  logic            clr_underrun;

  modport master (
    output en, in_valid, in_data, clr_underrun,
    input  in_ready, out_stb, out_data, level, underrun_cnt
  );

  modport slave (
    input  en, in_valid, in_data, clr_underrun,
    output in_ready, out_stb, out_data, level, underrun_cnt
  );
endinterface

// File: rtl/pdm_sample_feeder.sv
// Sample FIFO with a fixed-rate release divider for the PDM channel modulator.
// At every divider tick the head sample is released with a one-cycle strobe.
// If the FIFO is empty at a tick, the last sample is repeated and the underrun is counted.
module pdm_sample_feeder #(
  parameter int BITS  = 16,
  parameter int DEPTH = 16,
  parameter int DIV   = 256
) (
  input  logic              clk,
  input  logic              rst,
  pdm_sample_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIV);

  logic [CW-1:0]   div_q, div_d;
  logic            tick;

  logic [BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            full, empty, push, pop;

  logic [BITS-1:0] out_data_q, out_data_d;
  logic            out_stb_q, out_stb_d;
  logic [15:0]     underrun_q, underrun_d;

  // Occupancy flags come from registered state only.
  // A pop in the same cycle never reopens in_ready.
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.in_valid & bus.in_ready;
  assign pop   = tick & ~empty;

  assign bus.in_ready     = ~full & ~rst;
  assign bus.out_stb      = out_stb_q;
  assign bus.out_data     = out_data_q;
  assign bus.level        = level_q;
  assign bus.underrun_cnt = underrun_q;

  // Sample-period divider.
  // Disabling it parks the count at zero, so a fresh period starts when en rises.
  always_comb begin
    tick  = 1'b0;
    div_d = div_q;
    if (!bus.en) begin
      div_d = '0;
    end else if (div_q == CW'(DIV - 1)) begin
      tick  = 1'b1;
      div_d = '0;
    end else begin
      div_d = div_q + CW'(1);
    end
  end

  // Pointer and occupancy update.
  // A simultaneous push and pop leaves the level unchanged.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Output sample selection and underrun accounting at each sample instant.
  // A clear takes priority over an increment in the same cycle.
  always_comb begin
    out_stb_d  = tick;
    out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;
    underrun_d = underrun_q;
    if (tick && empty && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
    if (bus.clr_underrun) begin
      underrun_d = '0;
    end
  end

  // Sample storage.
  // It needs no reset because the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Control and output state registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      out_stb_q  <= 1'b0;
      underrun_q <= '0;
    end else begin
      div_q      <= div_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      out_stb_q  <= out_stb_d;
      underrun_q <= underrun_d;
    end
  end
endmodule

// File: tb/tb_pdm_sample_feeder.sv
// Directed bench for pdm_sample_feeder (BITS=16, DEPTH=4, DIV=4).
// A queue-based reference model is updated on every rising edge.
// The DUT outputs are compared with it on every falling edge.
// Literal checks placed in the stimulus pin the model to hand-computed values.
module tb_pdm_sample_feeder;
  localparam int BITS  = 16;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pdm_sample_feeder_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();

  pdm_sample_feeder #(.BITS(BITS), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [15:0] mq [$];
  logic [15:0] m_data;
  logic        m_stb;
  logic [15:0] m_under;
  int          run_len;
  bit          checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a tick fires on every DIV-th consecutive cycle with en high.
  always @(posedge clk) begin
    bit tk, psh;
    if (rst) begin
      mq.delete();
      m_data   = '0;
      m_stb    = 1'b0;
      m_under  = '0;
      run_len  = 0;
      checking = 1;
    end else begin
      tk      = bus.en && (((run_len + 1) % DIV) == 0);
      run_len = bus.en ? run_len + 1 : 0;
      psh     = bus.in_valid && (mq.size() < DEPTH);
      m_stb   = tk;
      if (tk) begin
        if (mq.size() > 0) m_data = mq.pop_front();
        else if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
      end
      if (bus.clr_underrun) m_under = '0;
      if (psh) mq.push_back(bus.in_data);
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (checking) begin
      chk("m_out_stb",  {31'd0, bus.out_stb}, {31'd0, m_stb});
      chk("m_out_data", {16'd0, bus.out_data}, {16'd0, m_data});
      chk("m_level",    {29'd0, bus.level}, mq.size());
      chk("m_underrun", {16'd0, bus.underrun_cnt}, {16'd0, m_under});
      chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, (!rst && mq.size() < DEPTH)});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] pre [3];
    pre[0] = 16'h0011; pre[1] = 16'h0022; pre[2] = 16'h0033;

    rst = 1'b1;
    bus.en = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.clr_underrun = 1'b0;
    cyc(2);
    chk("rst_level", {29'd0, bus.level}, 0);
    chk("rst_stb", {31'd0, bus.out_stb}, 0);
    chk("rst_data", {16'd0, bus.out_data}, 0);
    chk("rst_ready", {31'd0, bus.in_ready}, 0);
    rst = 1'b0;

    // T1: pre-fill with en low, then release at the sample rate
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = pre[i]; cyc(1);
    end
    bus.in_valid = 1'b0;
    chk("t1_level3", {29'd0, bus.level}, 3);
    bus.en = 1'b1;
    cyc(3); chk("t1_nostb", {31'd0, bus.out_stb}, 0);
    cyc(1); chk("t1_stb4", {31'd0, bus.out_stb}, 1); chk("t1_d4", {16'd0, bus.out_data}, 32'h11);
    chk("t1_lvl2", {29'd0, bus.level}, 2);
    cyc(4); chk("t1_d8", {16'd0, bus.out_data}, 32'h22);
    cyc(4); chk("t1_d12", {16'd0, bus.out_data}, 32'h33); chk("t1_lvl0", {29'd0, bus.level}, 0);

    // T2: underruns repeat the last sample, then a clear
    cyc(4); chk("t2_stb16", {31'd0, bus.out_stb}, 1); chk("t2_d16", {16'd0, bus.out_data}, 32'h33);
    cyc(4); chk("t2_under2", {16'd0, bus.underrun_cnt}, 2); chk("t2_d20", {16'd0, bus.out_data}, 32'h33);
    bus.clr_underrun = 1'b1; cyc(1); bus.clr_underrun = 1'b0;
    chk("t2_clr", {16'd0, bus.underrun_cnt}, 0);

    // T3: fill to full with en low
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h00A0 + 16'(i); cyc(1);
    end
    chk("t3_ready0", {31'd0, bus.in_ready}, 0);
    bus.in_data = 16'h00A5;
    cyc(2); chk("t3_level4", {29'd0, bus.level}, 4); chk("t3_ready_hold", {31'd0, bus.in_ready}, 0);

    // T4: full FIFO with a pending push; the push lands in the cycle after the pop
    bus.en = 1'b1;
    cyc(3); chk("t4_lvl4_pre", {29'd0, bus.level}, 4);
    cyc(1); chk("t4_pop_d", {16'd0, bus.out_data}, 32'hA0); chk("t4_pop_lvl", {29'd0, bus.level}, 3);
    chk("t4_ready1", {31'd0, bus.in_ready}, 1);
    cyc(1); chk("t4_refill", {29'd0, bus.level}, 4);
    bus.in_valid = 1'b0;
    cyc(3); chk("t4_dA1", {16'd0, bus.out_data}, 32'hA1);
    cyc(4); chk("t4_dA2", {16'd0, bus.out_data}, 32'hA2);
    cyc(4); chk("t4_dA3", {16'd0, bus.out_data}, 32'hA3);
    cyc(4); chk("t4_dA5", {16'd0, bus.out_data}, 32'hA5); chk("t4_lvl0", {29'd0, bus.level}, 0);

    // T5: drop en mid-period; the next strobe comes DIV cycles after en rises
    cyc(2); bus.en = 1'b0;
    cyc(2); chk("t5_nostb_off", {31'd0, bus.out_stb}, 0);
    bus.en = 1'b1;
    cyc(3); chk("t5_nostb_early", {31'd0, bus.out_stb}, 0);
    cyc(1); chk("t5_stb", {31'd0, bus.out_stb}, 1);

    // T6: reset mid-period with three samples buffered
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'h00B1 + 16'(i); cyc(1);
    end
    bus.in_valid = 1'b0; bus.en = 1'b1;
    cyc(2); rst = 1'b1;
    cyc(1);
    chk("t6_lvl", {29'd0, bus.level}, 0); chk("t6_data", {16'd0, bus.out_data}, 0);
    chk("t6_stb", {31'd0, bus.out_stb}, 0); chk("t6_under", {16'd0, bus.underrun_cnt}, 0);
    chk("t6_ready_rst", {31'd0, bus.in_ready}, 0);
    cyc(1); chk("t6_ready_rst2", {31'd0, bus.in_ready}, 0);
    bus.en = 1'b0; rst = 1'b0;
    #1 chk("t6_ready_rel", {31'd0, bus.in_ready}, 1);

    // T7: preload the counter near its limit, then three empty ticks saturate it
    force dut.underrun_q = 16'hFFFE;
    m_under = 16'hFFFE;
    cyc(1);
    release dut.underrun_q;
    cyc(1); chk("t7_preload", {16'd0, bus.underrun_cnt}, 32'hFFFE);
    bus.en = 1'b1;
    cyc(4); chk("t7_ffff", {16'd0, bus.underrun_cnt}, 32'hFFFF);
    cyc(8); chk("t7_sat", {16'd0, bus.underrun_cnt}, 32'hFFFF);

    // T8: a push on an empty-FIFO tick still counts as an underrun and pops next tick.
    // A clear on a tick beats the increment.
    bus.clr_underrun = 1'b1; cyc(1); bus.clr_underrun = 1'b0;
    cyc(2);
    bus.in_valid = 1'b1; bus.in_data = 16'h00C7; cyc(1); bus.in_valid = 1'b0;
    chk("t8_under1", {16'd0, bus.underrun_cnt}, 1); chk("t8_lvl1", {29'd0, bus.level}, 1);
    chk("t8_nobypass", {16'd0, bus.out_data}, 0);
    cyc(4); chk("t8_dC7", {16'd0, bus.out_data}, 32'hC7); chk("t8_lvl0", {29'd0, bus.level}, 0);
    cyc(3); bus.clr_underrun = 1'b1;
    cyc(1); bus.clr_underrun = 1'b0;
    chk("t8_clr_wins", {16'd0, bus.underrun_cnt}, 0); chk("t8_clr_stb", {31'd0, bus.out_stb}, 1);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
